// File: rtl/round_sequencer_if.sv
// Signal bundle between the round sequencer, the game-state driver and the mole manager.
// Members carry i_/o_ prefixes as seen from the sequencer.
interface round_sequencer_if;
    logic       i_start;
    logic [7:0] i_btn;
    logic [3:0] i_mole_pos;
    logic       o_mgr_enable;
    logic [1:0] o_mgr_stage;
    logic [2:0] o_countdown_s;
    logic [5:0] o_time_left_s;
    logic [9:0] o_score;
    logic [7:0] o_miss_cnt;
    logic       o_game_over;

    modport master (
        output i_start, i_btn, i_mole_pos,
        input  o_mgr_enable, o_mgr_stage, o_countdown_s, o_time_left_s,
               o_score, o_miss_cnt, o_game_over
    );

    modport slave (
        input  i_start, i_btn, i_mole_pos,
        output o_mgr_enable, o_mgr_stage, o_countdown_s, o_time_left_s,
               o_score, o_miss_cnt, o_game_over
    );
endinterface

// File: rtl/round_sequencer.sv
// Game-flow controller: countdown, three timed difficulty stages, hit/miss judging
// against the shown mole, and saturating score/miss counters.
module round_sequencer #(
    parameter int TICK_DIV    = 1000,
    parameter int MS_PER_S    = 1000,
    parameter int COUNTDOWN_S = 3,
    parameter int STAGE_S     = 20
) (
    input logic              clk_1mhz,
    input logic              rst,
    round_sequencer_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MS_MAX   = MW'(MS_PER_S - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [MW-1:0] r_ms_cnt;
    logic          r_mgr_enable;
    logic [1:0]    r_mgr_stage;
    logic [2:0]    r_countdown;
    logic [5:0]    r_time_left;
    logic [9:0]    r_score;
    logic [7:0]    r_miss;
    logic          r_game_over;
    logic          r_hit_lock;
    logic [3:0]    r_mole_q;

    logic       w_running;
    logic       w_tick;
    logic       w_sec;
    logic       w_begin;
    logic       w_cd_done;
    logic       w_stage_end;
    logic       w_game_end;
    logic       w_clear;
    logic       w_mole_valid;
    logic [2:0] w_idx;
    logic       w_lock_eff;
    logic       w_judge;
    logic       w_hit;
    logic       w_miss;

    assign w_running   = (r_state == S_COUNT) || (r_state == S_PLAY);
    assign w_tick      = w_running && (r_tick_cnt == TICK_MAX);
    assign w_sec       = w_tick && (r_ms_cnt == MS_MAX);
    assign w_begin     = bus.i_start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_cd_done   = (r_state == S_COUNT) && w_sec && (r_countdown == 3'd1);
    assign w_stage_end = (r_state == S_PLAY) && w_sec && (r_time_left == 6'd1);
    assign w_game_end  = w_stage_end && (r_mgr_stage == 2'd3);
    assign w_clear     = w_begin || w_cd_done || w_stage_end;

    // Mole 8 wraps to index 7 through the 3-bit subtraction.
    assign w_mole_valid = (bus.i_mole_pos != 4'd0) && (bus.i_mole_pos <= 4'd8);
    assign w_idx        = bus.i_mole_pos[2:0] - 3'd1;
    assign w_lock_eff   = r_hit_lock && (bus.i_mole_pos == r_mole_q);
    assign w_judge      = (r_state == S_PLAY) && (bus.i_btn != 8'd0) && !w_game_end;
    assign w_hit        = w_judge && w_mole_valid && bus.i_btn[w_idx] && !w_lock_eff;
    assign w_miss       = w_judge && !w_hit;

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_ms_cnt   <= '0;
        end else if (!w_running || w_clear) begin
            r_tick_cnt <= '0;
            r_ms_cnt   <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_ms_cnt   <= (r_ms_cnt == MS_MAX) ? '0 : r_ms_cnt + 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Enable drops for the single cycle after a stage change, then PLAY restores it.
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mgr_enable <= 1'b0;
            r_mgr_stage  <= 2'd0;
            r_countdown  <= 3'd0;
            r_time_left  <= 6'd0;
            r_game_over  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (bus.i_start) begin
                        r_state     <= S_COUNT;
                        r_countdown <= 3'(COUNTDOWN_S);
                        r_game_over <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (w_cd_done) begin
                        r_state      <= S_PLAY;
                        r_countdown  <= 3'd0;
                        r_mgr_stage  <= 2'd1;
                        r_time_left  <= 6'(STAGE_S);
                        r_mgr_enable <= 1'b1;
                    end else if (w_sec) begin
                        r_countdown <= r_countdown - 3'd1;
                    end
                end
                default: begin
                    r_mgr_enable <= 1'b1;
                    if (w_game_end) begin
                        r_state      <= S_OVER;
                        r_mgr_enable <= 1'b0;
                        r_mgr_stage  <= 2'd0;
                        r_time_left  <= 6'd0;
                        r_game_over  <= 1'b1;
                    end else if (w_stage_end) begin
                        r_mgr_stage  <= r_mgr_stage + 2'd1;
                        r_time_left  <= 6'(STAGE_S);
                        r_mgr_enable <= 1'b0;
                    end else if (w_sec) begin
                        r_time_left <= r_time_left - 6'd1;
                    end
                end
            endcase
        end
    end

    // A mole may be hit once per appearance; a new position or a new stage re-arms it.
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            r_score    <= 10'd0;
            r_miss     <= 8'd0;
            r_hit_lock <= 1'b0;
            r_mole_q   <= 4'd0;
        end else begin
            r_mole_q <= bus.i_mole_pos;
            if (w_begin) begin
                r_score <= 10'd0;
                r_miss  <= 8'd0;
            end else begin
                if (w_hit && (r_score != 10'd999)) r_score <= r_score + 10'd1;
                if (w_miss && (r_miss != 8'd255))  r_miss  <= r_miss + 8'd1;
            end
            if ((r_state != S_PLAY) || w_stage_end) r_hit_lock <= 1'b0;
            else if (w_hit)                         r_hit_lock <= 1'b1;
            else                                    r_hit_lock <= w_lock_eff;
        end
    end

    assign bus.o_mgr_enable  = r_mgr_enable;
    assign bus.o_mgr_stage   = r_mgr_stage;
    assign bus.o_countdown_s = r_countdown;
    assign bus.o_time_left_s = r_time_left;
    assign bus.o_score       = r_score;
    assign bus.o_miss_cnt    = r_miss;
    assign bus.o_game_over   = r_game_over;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: a timeline model of the main instance checked every cycle,
// plus directed literal checks; a second long-stage instance exercises saturation.
module tb_round_sequencer;

    localparam int TD       = 4;
    localparam int MS       = 5;
    localparam int CD_S     = 3;
    localparam int ST_S     = 2;
    localparam int SEC      = TD * MS;
    localparam int CD_CYC   = CD_S * SEC;
    localparam int ST_CYC   = ST_S * SEC;
    localparam int END_CYC  = CD_CYC + 3 * ST_CYC;

    logic clk_1mhz = 1'b0;
    logic rst      = 1'b1;
    int   errors   = 0;
    int   checks   = 0;

    always #5 clk_1mhz = ~clk_1mhz;

    round_sequencer_if bus1 ();
    round_sequencer_if bus2 ();

    round_sequencer #(.TICK_DIV(TD), .MS_PER_S(MS), .COUNTDOWN_S(CD_S), .STAGE_S(ST_S)) dut (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .bus      (bus1)
    );

    round_sequencer #(.TICK_DIV(TD), .MS_PER_S(MS), .COUNTDOWN_S(3), .STAGE_S(30)) dut2 (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .bus      (bus2)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int which, input bit s, input logic [7:0] b,
                                 input logic [3:0] m);
        if (which == 1) begin
            bus1.i_start = s; bus1.i_btn = b; bus1.i_mole_pos = m;
        end else begin
            bus2.i_start = s; bus2.i_btn = b; bus2.i_mole_pos = m;
        end
        @(posedge clk_1mhz);
        #1;
        bus1.i_start = 1'b0;
        bus2.i_start = 1'b0;
    endtask

    // Model: elapsed edges since the start edge define the whole timeline.
    bit         mRun;
    int         mT;
    int         mScore;
    int         mMiss;
    bit         mLock;
    logic [3:0] mMoleQ;

    always @(posedge clk_1mhz or posedge rst) begin
        bit playing, leaving, idleOrOver, sameMole, hit, miss, newStage;
        logic [7:0] b;
        logic [3:0] m;
        int idx;
        if (rst) begin
            mRun <= 1'b0; mT <= 0; mScore <= 0; mMiss <= 0; mLock <= 1'b0; mMoleQ <= 4'd0;
        end else begin
            b = bus1.i_btn;
            m = bus1.i_mole_pos;
            playing    = mRun && (mT >= CD_CYC) && (mT < END_CYC);
            idleOrOver = !mRun || (mT >= END_CYC);
            leaving    = playing && (mT + 1 == END_CYC);
            newStage   = playing && (((mT + 1 - CD_CYC) % ST_CYC) == 0);
            sameMole   = (m == mMoleQ);
            hit = 1'b0;
            miss = 1'b0;
            if (playing && !leaving && (b != 8'd0)) begin
                idx = int'(m) - 1;
                if ((m >= 1) && (m <= 8) && b[idx] && !(mLock && sameMole)) hit = 1'b1;
                else miss = 1'b1;
            end
            if (idleOrOver && bus1.i_start) begin
                mRun <= 1'b1; mT <= 0; mScore <= 0; mMiss <= 0;
            end else begin
                if (mRun && (mT < END_CYC)) mT <= mT + 1;
                if (hit && (mScore < 999)) mScore <= mScore + 1;
                if (miss && (mMiss < 255)) mMiss <= mMiss + 1;
            end
            mLock  <= (playing && !newStage) ? (hit || (mLock && sameMole)) : 1'b0;
            mMoleQ <= m;
        end
    end

    always @(negedge clk_1mhz) begin
        int ecd, etl, estg, p;
        bit een, ego;
        if (!rst) begin
            ecd = 0; etl = 0; estg = 0; een = 1'b0; ego = 1'b0;
            if (mRun && (mT < CD_CYC)) begin
                ecd = CD_S - mT / SEC;
            end else if (mRun && (mT < END_CYC)) begin
                p    = mT - CD_CYC;
                estg = 1 + p / ST_CYC;
                etl  = ST_S - (p % ST_CYC) / SEC;
                een  = !((p % ST_CYC == 0) && (p != 0));
            end else if (mRun) begin
                ego = 1'b1;
            end
            checkOutput("model countdown_s", bus1.o_countdown_s, ecd);
            checkOutput("model time_left_s", bus1.o_time_left_s, etl);
            checkOutput("model mgr_stage", bus1.o_mgr_stage, estg);
            checkOutput("model mgr_enable", bus1.o_mgr_enable, een);
            checkOutput("model game_over", bus1.o_game_over, ego);
            checkOutput("model score", bus1.o_score, mScore);
            checkOutput("model miss_cnt", bus1.o_miss_cnt, mMiss);
        end
    end

    initial begin
        int tt;
        bus1.i_start = 1'b0; bus1.i_btn = 8'd0; bus1.i_mole_pos = 4'd0;
        bus2.i_start = 1'b0; bus2.i_btn = 8'd0; bus2.i_mole_pos = 4'd0;
        #2;
        checkOutput("reset enable", bus1.o_mgr_enable, 0);
        checkOutput("reset stage", bus1.o_mgr_stage, 0);
        checkOutput("reset countdown", bus1.o_countdown_s, 0);
        checkOutput("reset score", bus1.o_score, 0);
        checkOutput("reset game_over", bus1.o_game_over, 0);
        repeat (3) @(posedge clk_1mhz);
        #1 rst = 1'b0;

        // Countdown and entry into PLAY
        applyStimulus(1, 1'b1, 8'd0, 4'd0);
        tt = 0;
        checkOutput("cd start", bus1.o_countdown_s, 3);
        while (tt < 60) begin
            applyStimulus(1, 1'b0, 8'd0, 4'd0);
            tt++;
            if (tt == 20) checkOutput("cd at 20", bus1.o_countdown_s, 2);
            if (tt == 40) checkOutput("cd at 40", bus1.o_countdown_s, 1);
            if (tt == 59) checkOutput("enable before play", bus1.o_mgr_enable, 0);
        end
        checkOutput("play enable", bus1.o_mgr_enable, 1);
        checkOutput("play stage", bus1.o_mgr_stage, 1);
        checkOutput("play time_left", bus1.o_time_left_s, 2);
        checkOutput("play countdown", bus1.o_countdown_s, 0);

        // Hit, relock and miss cases
        applyStimulus(1, 1'b0, 8'h00, 4'd5);
        applyStimulus(1, 1'b0, 8'h10, 4'd5);
        checkOutput("first hit score", bus1.o_score, 1);
        applyStimulus(1, 1'b0, 8'h10, 4'd5);
        checkOutput("relock miss", bus1.o_miss_cnt, 1);
        checkOutput("relock score", bus1.o_score, 1);
        applyStimulus(1, 1'b0, 8'h00, 4'd2);
        applyStimulus(1, 1'b0, 8'h02, 4'd2);
        checkOutput("new mole score", bus1.o_score, 2);
        applyStimulus(1, 1'b0, 8'h01, 4'd0);
        checkOutput("no mole miss", bus1.o_miss_cnt, 2);
        applyStimulus(1, 1'b0, 8'h00, 4'd3);
        applyStimulus(1, 1'b0, 8'h05, 4'd3);
        checkOutput("multi-bit hit score", bus1.o_score, 3);
        checkOutput("multi-bit hit miss", bus1.o_miss_cnt, 2);
        applyStimulus(1, 1'b0, 8'h01, 4'd3);
        checkOutput("wrong button miss", bus1.o_miss_cnt, 3);
        applyStimulus(1, 1'b0, 8'h80, 4'd8);
        checkOutput("same-cycle change hit", bus1.o_score, 4);
        tt = 70;

        // Stage progression through to OVER; a press on the final edge is dropped
        while (tt < 180) begin
            if (tt + 1 == 180) applyStimulus(1, 1'b0, 8'h01, 4'd1);
            else               applyStimulus(1, 1'b0, 8'h00, 4'd0);
            tt++;
            if (tt == 99)  checkOutput("stage1 last tl", bus1.o_time_left_s, 1);
            if (tt == 100) checkOutput("gap1 enable", bus1.o_mgr_enable, 0);
            if (tt == 100) checkOutput("gap1 stage", bus1.o_mgr_stage, 2);
            if (tt == 101) checkOutput("after gap1 enable", bus1.o_mgr_enable, 1);
            if (tt == 140) checkOutput("gap2 enable", bus1.o_mgr_enable, 0);
            if (tt == 140) checkOutput("gap2 stage", bus1.o_mgr_stage, 3);
            if (tt == 141) checkOutput("after gap2 enable", bus1.o_mgr_enable, 1);
            if (tt == 179) checkOutput("not over at 179", bus1.o_game_over, 0);
        end
        checkOutput("over game_over", bus1.o_game_over, 1);
        checkOutput("over enable", bus1.o_mgr_enable, 0);
        checkOutput("over stage", bus1.o_mgr_stage, 0);
        checkOutput("over score held", bus1.o_score, 4);
        checkOutput("over miss held", bus1.o_miss_cnt, 3);

        // Saturation and restart on the long-stage instance
        applyStimulus(2, 1'b1, 8'd0, 4'd0);
        repeat (60) applyStimulus(2, 1'b0, 8'd0, 4'd0);
        checkOutput("dut2 play stage", bus2.o_mgr_stage, 1);
        for (int i = 0; i < 1010; i++) begin
            if (i % 2 == 0) applyStimulus(2, 1'b0, 8'h01, 4'd1);
            else            applyStimulus(2, 1'b0, 8'h02, 4'd2);
        end
        checkOutput("dut2 score saturated", bus2.o_score, 999);
        for (int i = 0; i < 300; i++) applyStimulus(2, 1'b0, 8'h01, 4'd0);
        checkOutput("dut2 miss saturated", bus2.o_miss_cnt, 255);
        checkOutput("dut2 score still", bus2.o_score, 999);
        for (int i = 0; i < 1000 && bus2.o_game_over !== 1'b1; i++)
            applyStimulus(2, 1'b0, 8'd0, 4'd0);
        checkOutput("dut2 game_over", bus2.o_game_over, 1);
        checkOutput("dut2 over score", bus2.o_score, 999);
        applyStimulus(2, 1'b1, 8'd0, 4'd0);
        checkOutput("dut2 restart score", bus2.o_score, 0);
        checkOutput("dut2 restart miss", bus2.o_miss_cnt, 0);
        checkOutput("dut2 restart countdown", bus2.o_countdown_s, 3);
        checkOutput("dut2 restart game_over", bus2.o_game_over, 0);

        // Restart main instance from OVER, then reset asynchronously mid-PLAY
        applyStimulus(1, 1'b1, 8'd0, 4'd0);
        checkOutput("restart countdown", bus1.o_countdown_s, 3);
        checkOutput("restart score", bus1.o_score, 0);
        checkOutput("restart game_over", bus1.o_game_over, 0);
        repeat (61) applyStimulus(1, 1'b0, 8'd0, 4'd4);
        applyStimulus(1, 1'b0, 8'h08, 4'd4);
        checkOutput("pre-reset score", bus1.o_score, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async enable", bus1.o_mgr_enable, 0);
        checkOutput("async stage", bus1.o_mgr_stage, 0);
        checkOutput("async time_left", bus1.o_time_left_s, 0);
        checkOutput("async score", bus1.o_score, 0);
        checkOutput("async miss", bus1.o_miss_cnt, 0);
        repeat (2) @(posedge clk_1mhz);
        #1 rst = 1'b0;
        applyStimulus(1, 1'b1, 8'd0, 4'd0);
        checkOutput("post-reset countdown", bus1.o_countdown_s, 3);
        repeat (5) applyStimulus(1, 1'b0, 8'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Top-level game-flow controller sitting between the game-state logic and the in-game mole manager. It runs the countdown, drives the mole manager's enable and difficulty stage, and times each stage. It judges button presses against the currently shown mole and keeps score and miss counts until the game ends.

## Interface
- TICK_DIV, 1000: clk_1mhz cycles per 1 ms tick.
- MS_PER_S, 1000: ticks per second.
- COUNTDOWN_S, 3: pre-game countdown length in seconds (1..7).
- STAGE_S, 20: length of each stage in seconds (1..63).
- clk_1mhz  in  1  system clock, 1 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle synchronous pulse; begins a game from IDLE or OVER.
- btn  in  8  single-cycle synchronous press pulses; btn[i] hits mole position i+1.
- mole_pos  in  4  current mole from the mole manager: 0 = none, 1..8 = shown position.
- mgr_enable  out  1  enable to the mole manager.
- mgr_stage  out  2  difficulty stage to the mole manager: 0 = idle, 1..3 = stage.
- countdown_s  out  3  seconds remaining in the countdown; 0 outside COUNTDOWN.
- time_left_s  out  6  seconds remaining in the current stage; 0 outside PLAY.
- score  out  10  hit count, saturating at 999.
- miss_cnt  out  8  miss count, saturating at 255.
- game_over  out  1  high in the OVER state.

## Operation
- States: IDLE, COUNTDOWN, PLAY, OVER. Reset forces IDLE, and every output is 0.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and emits a tick on the cycle it holds TICK_DIV-1.
  - Held at 0 in IDLE and OVER.
  - Cleared on every state change and on every stage change.
- Second counter: counts ticks 0..MS_PER_S-1. The cycle that wraps it is a second strobe. Cleared together with the prescaler.
- IDLE:
  - On start: go to COUNTDOWN, countdown_s = COUNTDOWN_S, and clear score and miss_cnt.
  - btn is ignored.
- COUNTDOWN:
  - Each second strobe decrements countdown_s.
  - On the strobe where countdown_s = 1: go to PLAY with countdown_s = 0, mgr_stage = 1, time_left_s = STAGE_S and mgr_enable = 1.
  - start and btn are ignored.
- PLAY, hit judging. Evaluated every cycle in which btn ≠ 0:
  - Hit: mole_pos ≠ 0, btn[mole_pos-1] = 1 and hit_lock = 0. Then score += 1 (saturating) and hit_lock is set.
  - Miss: any other case, including a press on an already-hit mole or on no mole. Then miss_cnt += 1 (saturating).
  - At most one event per cycle. If the matching bit and other bits are set together, only the hit is counted.
- hit_lock:
  - Cleared whenever mole_pos differs from its value on the previous cycle (mole_pos_q).
  - A press in that same cycle is judged with the lock already cleared.
- PLAY, stage timing:
  - Each second strobe decrements time_left_s.
  - On the strobe where time_left_s = 1 and mgr_stage < 3: mgr_stage += 1, time_left_s = STAGE_S, and mgr_enable is driven 0 for exactly one cycle so the manager restarts its pattern. hit_lock is cleared.
  - On the strobe where time_left_s = 1 and mgr_stage = 3: go to OVER.
  - start is ignored in PLAY.
- OVER:
  - mgr_enable = 0, mgr_stage = 0, time_left_s = 0, game_over = 1.
  - score and miss_cnt are held.
  - start behaves as in IDLE, and game_over drops on the same edge.
- mole_pos is used only in PLAY. In other states hit_lock is held at 0.

## Timing
- All outputs are registered and update on the rising edge of clk_1mhz. There is no combinational input-to-output path.
- Press-to-count latency:
  - A btn pulse sampled at edge N is reflected in score or miss_cnt after edge N.
  - A btn pulse in the same cycle as a state transition out of PLAY is not counted.
- The countdown→PLAY edge also asserts mgr_enable. The mole manager sees enable for the first time in the following cycle.
- The stage-change gap is exactly one clk_1mhz cycle with mgr_enable = 0. On the next edge mgr_enable returns to 1 and mgr_stage holds the new value.
- Game length from the start pulse to game_over = 1 is (COUNTDOWN_S + 3·STAGE_S)·MS_PER_S·TICK_DIV + 1 cycles.
- Asynchronous rst mid-game: all outputs reach 0 immediately and the block is in IDLE on release. The first start after release is honoured.

## Test plan
All scenarios use TICK_DIV=4, MS_PER_S=5, COUNTDOWN_S=3, STAGE_S=2.
1. Countdown: pulse start from reset → countdown_s steps 3,2,1 at 20-cycle intervals. Exactly 61 cycles after the start edge, mgr_enable=1, mgr_stage=1 and time_left_s=2.
2. Hit and relock: in PLAY, mole_pos=5, pulse btn[4] → score=1. Pulse btn[4] again → miss_cnt=1, score=1. Change mole_pos to 2, pulse btn[1] → score=2.
3. Miss cases:
   - mole_pos=0 with btn=8'h01 → miss_cnt+1.
   - mole_pos=3 with btn=8'h05 (bits 0 and 2) → score+1 and no miss.
   - mole_pos=3 with btn=8'h01 → miss_cnt+1.
4. Stage progression: run PLAY to completion → mgr_stage goes 1→2→3. At each change mgr_enable is 0 for exactly one cycle. After stage 3 expires, game_over=1, mgr_enable=0 and score is held. Total run from start is 181 cycles.
5. Saturation and restart:
   - Force score to 999 via 1000+ hits → score remains 999.
   - Force 300 misses → miss_cnt=255.
   - Pulse start in OVER → score=0, miss_cnt=0, countdown_s=3, game_over=0.
6. Reset mid-PLAY: assert rst asynchronously between edges → all outputs are 0 before the next edge. Release, then pulse start → the countdown restarts at 3.
